// File: rtl/tcb_htif_pkg.sv
// rtl/tcb_htif_pkg.sv - shared types and constants for the TCB HTIF responder
//
// Purpose: register offset enum, TCB transfer size encodings, STATUS bit
// positions and a small decode helper used by tcb_htif_responder.
// Ports: none (package).

package tcb_htif_pkg;

  // Register offsets within the 16-byte window, selected by adr[3:2].
  typedef enum logic [1:0] {
    REG_TOHOST   = 2'd0,
    REG_FROMHOST = 2'd1,
    REG_CONSOLE  = 2'd2,
    REG_STATUS   = 2'd3
  } htif_reg_e;

  // TCB transfer size, fn3[1:0].
  typedef enum logic [1:0] {
    SIZ_BYTE = 2'd0,
    SIZ_HALF = 2'd1,
    SIZ_WORD = 2'd2,
    SIZ_RSV  = 2'd3
  } tcb_siz_e;

  // STATUS register layout.
  localparam int unsigned STS_HALT    = 0;
  localparam int unsigned STS_FULL    = 1;
  localparam int unsigned STS_EMPTY   = 2;
  localparam int unsigned STS_CNT_LSB = 8;
  localparam int unsigned STS_CNT_W   = 8;

  // TOHOST and FROMHOST only accept aligned word accesses.
  function automatic logic is_word_reg(htif_reg_e r);
    return (r == REG_TOHOST) || (r == REG_FROMHOST);
  endfunction

endpackage

// File: rtl/tcb_htif_fifo.sv
// rtl/tcb_htif_fifo.sv - synchronous console byte FIFO
//
// Purpose: power-of-two deep FIFO with free-running wrapping pointers and an
// explicit occupancy counter one bit wider than the pointers.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push, push_dat write request and data (ignored when full)
//   pop            read request (ignored when empty)
//   head           oldest entry, valid while empty is low
//   full, empty    occupancy flags
//   count          number of stored entries, 0..DEPTH

module tcb_htif_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tcb_htif_responder.sv
// rtl/tcb_htif_responder.sv - TCB subordinate implementing the HTIF host interface
//
// Purpose: tohost/fromhost registers, sticky halt with exit code, and a
// console byte FIFO drained through a valid/ready stream.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tcb_vld/wen/adr/fn3/wdt  TCB request
//   tcb_rdt, tcb_err    registered response, one cycle after the transfer
//   tcb_rdy             low only while a console write waits on a full FIFO
//   con_vld/dat/rdy     console byte stream
//   halt, exit_code     sticky halt flag and tohost[31:1] captured at halt

module tcb_htif_responder
  import tcb_htif_pkg::*;
#(
  parameter int unsigned    ABW        = 32,
  parameter int unsigned    DBW        = 32,
  parameter logic [ABW-1:0] ADR_BASE   = 32'h8040_0000,
  parameter int unsigned    FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tcb_vld,
  input  logic           tcb_wen,
  input  logic [ABW-1:0] tcb_adr,
  input  logic [2:0]     tcb_fn3,
  input  logic [DBW-1:0] tcb_wdt,
  output logic [DBW-1:0] tcb_rdt,
  output logic           tcb_err,
  output logic           tcb_rdy,
  output logic           con_vld,
  output logic [7:0]     con_dat,
  input  logic           con_rdy,
  output logic           halt,
  output logic [30:0]    exit_code
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic           hit;
  htif_reg_e      off;
  tcb_siz_e       siz;
  logic           trn;
  logic           req_err;
  logic           wr_ok;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [7:0]     fifo_head;
  logic [DBW-1:0] tohost;
  logic [DBW-1:0] fromhost;
  logic [DBW-1:0] status;
  logic [DBW-1:0] rd_data;

  // The signedness bit of fn3 has no meaning for these registers.
  logic unused_uns;
  assign unused_uns = tcb_fn3[2];

  assign hit = (tcb_adr[ABW-1:4] == ADR_BASE[ABW-1:4]);
  assign off = htif_reg_e'(tcb_adr[3:2]);
  assign siz = tcb_siz_e'(tcb_fn3[1:0]);

  // Only a console write into a full FIFO stalls; a same-cycle pop does not
  // unblock it, so the push lands one cycle after space frees.
  assign tcb_rdy = ~(tcb_vld & tcb_wen & hit & (off == REG_CONSOLE) & fifo_full);
  assign trn     = tcb_vld & tcb_rdy;

  assign req_err = ~hit
                 | (siz == SIZ_RSV)
                 | (is_word_reg(off) & ((siz != SIZ_WORD) | (tcb_adr[1:0] != 2'b00)));

  assign wr_ok = trn & tcb_wen & ~req_err;
  assign push  = wr_ok & (off == REG_CONSOLE);

  assign con_vld = ~fifo_empty;
  assign con_dat = fifo_head;
  assign pop     = con_vld & con_rdy;

  tcb_htif_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (tcb_wdt[7:0]),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    status                             = '0;
    status[STS_HALT]                   = halt;
    status[STS_FULL]                   = fifo_full;
    status[STS_EMPTY]                  = fifo_empty;
    status[STS_CNT_LSB +: STS_CNT_W]   = STS_CNT_W'(fifo_count);
  end

  always_comb begin
    rd_data = '0;
    case (off)
      REG_TOHOST:   rd_data = tohost;
      REG_FROMHOST: rd_data = fromhost;
      REG_STATUS:   rd_data = status;
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcb_rdt   <= '0;
      tcb_err   <= 1'b0;
      tohost    <= '0;
      fromhost  <= '0;
      halt      <= 1'b0;
      exit_code <= '0;
    end else begin
      // Response holds between transfers; writes and errors return zero.
      if (trn) begin
        tcb_err <= req_err;
        tcb_rdt <= (tcb_wen | req_err) ? '0 : rd_data;
      end
      if (wr_ok && (off == REG_TOHOST)) begin
        tohost <= tcb_wdt;
        // First odd write halts; later writes leave halt and exit code alone.
        if (tcb_wdt[0] && !halt) begin
          halt      <= 1'b1;
          exit_code <= tcb_wdt[31:1];
        end
      end
      if (wr_ok && (off == REG_FROMHOST)) begin
        fromhost <= tcb_wdt;
      end
    end
  end

endmodule

// File: tb/tb_tcb_htif_responder.sv
// tb/tb_tcb_htif_responder.sv - scoreboard bench for tcb_htif_responder

module tb_tcb_htif_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h8040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        tcb_vld;
  logic        tcb_wen;
  logic [31:0] tcb_adr;
  logic [2:0]  tcb_fn3;
  logic [31:0] tcb_wdt;
  logic [31:0] tcb_rdt;
  logic        tcb_err;
  logic        tcb_rdy;
  logic        con_vld;
  logic [7:0]  con_dat;
  logic        con_rdy;
  logic        halt;
  logic [30:0] exit_code;

  tcb_htif_responder #(
    .ABW        (32),
    .DBW        (32),
    .ADR_BASE   (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tcb_vld   (tcb_vld),
    .tcb_wen   (tcb_wen),
    .tcb_adr   (tcb_adr),
    .tcb_fn3   (tcb_fn3),
    .tcb_wdt   (tcb_wdt),
    .tcb_rdt   (tcb_rdt),
    .tcb_err   (tcb_err),
    .tcb_rdy   (tcb_rdy),
    .con_vld   (con_vld),
    .con_dat   (con_dat),
    .con_rdy   (con_rdy),
    .halt      (halt),
    .exit_code (exit_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdt;
    logic        err;
    logic        halt;
    logic [30:0] exit;
  } resp_t;

  resp_t       exp_q[$];
  logic [7:0]  con_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic [31:0] m_tohost;
  logic [31:0] m_fromhost;
  logic        m_halt;
  logic [30:0] m_exit;
  int          m_cnt;
  int          rdy_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic model_reset();
    m_tohost   = '0;
    m_fromhost = '0;
    m_halt     = 1'b0;
    m_exit     = '0;
    m_cnt      = 0;
    exp_q.delete();
    con_q.delete();
  endtask

  function automatic logic [31:0] model_status();
    return 32'(m_cnt) * 32'd256 + (m_cnt == 0 ? 32'd4 : 32'd0)
         + (m_cnt == DEPTH ? 32'd2 : 32'd0) + (m_halt ? 32'd1 : 32'd0);
  endfunction

  task automatic model_xfer(input logic w, input logic [31:0] a, input logic [2:0] f,
                            input logic [31:0] d, output logic do_push);
    resp_t       e;
    logic        err;
    logic [1:0]  off;
    logic [1:0]  siz;
    logic [31:0] rd;
    off = a[3:2];
    siz = f[1:0];
    err = (a[31:4] != BASE[31:4]) || (siz == 2'd3)
        || ((off == 2'd0 || off == 2'd1) && (siz != 2'd2 || a[1:0] != 2'd0));
    do_push = 1'b0;
    rd = '0;
    if (!err) begin
      if (w) begin
        case (off)
          2'd0: begin
            m_tohost = d;
            if (d[0] && !m_halt) begin
              m_halt = 1'b1;
              m_exit = d[31:1];
            end
          end
          2'd1:    m_fromhost = d;
          2'd2:    do_push = 1'b1;
          default: ;
        endcase
      end else begin
        case (off)
          2'd0:    rd = m_tohost;
          2'd1:    rd = m_fromhost;
          2'd3:    rd = model_status();
          default: rd = '0;
        endcase
      end
    end
    e.rdt  = rd;
    e.err  = err;
    e.halt = m_halt;
    e.exit = m_exit;
    exp_q.push_back(e);
  endtask

  // Called 1 time unit after inputs change, before the next rising edge.
  task automatic eval_cycle(output logic was_trn);
    logic exp_rdy;
    logic push;
    logic pop;
    exp_rdy = !(tcb_vld && tcb_wen && tcb_adr[31:4] == BASE[31:4]
                && tcb_adr[3:2] == 2'd2 && m_cnt == DEPTH);
    if (tcb_vld) chk("tcb_rdy", 32'(tcb_rdy), 32'(exp_rdy));
    chk("con_vld", 32'(con_vld), 32'(m_cnt != 0));
    was_trn = tcb_vld && tcb_rdy;
    pop  = (m_cnt != 0) && con_rdy;
    push = 1'b0;
    if (was_trn) begin
      model_xfer(tcb_wen, tcb_adr, tcb_fn3, tcb_wdt, push);
      if (push) con_q.push_back(tcb_wdt[7:0]);
    end
    m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
  endtask

  task automatic cycle_begin(input int stalls);
    if (stalls >= 4) con_rdy = 1'b1;
    else if (rdy_mode == 1) con_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    logic t;
    repeat (n) begin
      cycle_begin(0);
      #1;
      eval_cycle(t);
      @(negedge clk);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [2:0] f,
                     input logic [31:0] d);
    int   stalls;
    logic t;
    stalls  = 0;
    tcb_vld = 1'b1;
    tcb_wen = w;
    tcb_adr = a;
    tcb_fn3 = f;
    tcb_wdt = d;
    forever begin
      cycle_begin(stalls);
      #1;
      eval_cycle(t);
      @(negedge clk);
      if (t) break;
      stalls++;
      if (stalls > 100) begin
        fail("rdy_timeout");
        break;
      end
    end
    tcb_vld = 1'b0;
    tcb_wen = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_cnt != 0 && n < 200) begin
      idle(1);
      n++;
    end
    if (m_cnt != 0) fail("drain_timeout");
  endtask

  // Monitor: checks responses one cycle after each handshake and every
  // console byte leaving the stream.
  logic pend = 1'b0;
  always @(negedge clk) begin
    resp_t e;
    #2;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          fail("resp_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("tcb_rdt", tcb_rdt, e.rdt);
          chk("tcb_err", 32'(tcb_err), 32'(e.err));
          chk("halt", 32'(halt), 32'(e.halt));
          chk("exit_code", 32'(exit_code), 32'(e.exit));
        end
      end
      pend = tcb_vld && tcb_rdy;
      if (con_vld && con_rdy) begin
        if (con_q.size() == 0) fail("con_unexpected");
        else chk("con_dat", 32'(con_dat), 32'(con_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdt"},  tcb_rdt, 32'd0);
    chk({tag, "_err"},  32'(tcb_err), 32'd0);
    chk({tag, "_halt"}, 32'(halt), 32'd0);
    chk({tag, "_exit"}, 32'(exit_code), 32'd0);
    chk({tag, "_cvld"}, 32'(con_vld), 32'd0);
    chk({tag, "_rdy"},  32'(tcb_rdy), 32'd1);
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    rst      = 1'b1;
    tcb_vld  = 1'b0;
    tcb_wen  = 1'b0;
    tcb_adr  = '0;
    tcb_fn3  = '0;
    tcb_wdt  = '0;
    con_rdy  = 1'b0;
    rdy_mode = 0;
    model_reset();

    #7;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // FROMHOST round trip
    bus(1'b1, BASE + 32'd4, 3'b010, 32'hDEAD_BEEF);
    bus(1'b0, BASE + 32'd4, 3'b010, 32'd0);

    // Halt with exit code 0, then sticky
    bus(1'b1, BASE, 3'b010, 32'h0000_0001);
    bus(1'b1, BASE, 3'b010, 32'h0000_002B);
    bus(1'b0, BASE, 3'b010, 32'd0);

    // Console backpressure: 16 fit, status, 17th stalls until con_rdy rises
    con_rdy = 1'b0;
    for (int i = 0; i < 16; i++) bus(1'b1, BASE + 32'd8, 3'b000, 32'(65 + i));
    bus(1'b0, BASE + 32'd12, 3'b010, 32'd0);
    bus(1'b1, BASE + 32'd8, 3'b000, 32'(81));
    drain();

    // Error cases, then tohost unchanged
    bus(1'b1, BASE, 3'b001, 32'hFFFF_FFFF);
    bus(1'b0, BASE + 32'd16, 3'b010, 32'd0);
    bus(1'b0, BASE + 32'd1, 3'b010, 32'd0);
    bus(1'b0, BASE, 3'b010, 32'd0);

    // Asynchronous reset with bytes queued and a nonzero response held
    bus(1'b1, BASE + 32'd4, 3'b010, 32'h1234_5678);
    con_rdy = 1'b0;
    for (int i = 0; i < 5; i++) bus(1'b1, BASE + 32'd8, 3'b000, 32'(97 + i));
    bus(1'b0, BASE + 32'd4, 3'b010, 32'd0);
    rdy_mode = 1;
    idle(2);
    rdy_mode = 0;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    con_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    idle(1);
    bus(1'b0, BASE + 32'd12, 3'b010, 32'd0);
    bus(1'b0, BASE, 3'b010, 32'd0);

    // Fresh halt with nonzero exit code
    bus(1'b1, BASE, 3'b010, 32'h0000_0055);
    idle(1);

    // Randomized traffic with random console backpressure
    rdy_mode = 1;
    repeat (400) begin
      r = int'($urandom_range(0, 9));
      d = $urandom;
      f = {1'($urandom_range(0, 1)), 2'd2};
      case (r)
        0, 1, 2: begin
          f[1:0] = 2'($urandom_range(0, 2));
          bus(1'b1, BASE + 32'd8 + 32'($urandom_range(0, 3)), f, d);
        end
        3: bus(1'b1, BASE + 32'd4, f, d);
        4: bus(1'b0, BASE + 32'd4, f, d);
        5: begin
          a = BASE + (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
          bus(1'b1, a, f, d);
        end
        6: bus(1'b0, BASE + 32'd12, f, 32'd0);
        7: bus(1'b0, BASE + 32'($urandom_range(0, 15)), f, 32'd0);
        8: begin
          if ($urandom_range(0, 1) == 1) begin
            f[1:0] = 2'd3;
            a = BASE + 32'($urandom_range(0, 15));
          end else begin
            a = BASE ^ (32'd1 << $urandom_range(4, 31));
          end
          bus(1'($urandom_range(0, 1)), a, f, d);
        end
        default: begin
          f = 3'($urandom_range(0, 7));
          bus(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 15)), f, d);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle(1 + int'($urandom_range(0, 2)));
    end

    rdy_mode = 0;
    con_rdy  = 1'b1;
    drain();
    idle(3);
    chk("resp_queue_left", 32'(exp_q.size()), 32'd0);
    chk("con_queue_left", 32'(con_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcb_htif_responder.md
Name: tcb_htif_responder

Overview:
- Synthesizable TCB responder (subordinate) for the system bus that the r5p_mouse core drives as initiator.
- Implements the HTIF host interface: tohost/fromhost registers, a sticky halt with exit code, and a console byte FIFO drained through a valid/ready stream.
- Placed on the shared TCB bus, behind an address decoder, next to memory; used by benches and FPGA images to end runs and print characters.

Parameters:
- ABW, 32, TCB address width.
- DBW, 32, TCB data width; only 32 is supported.
- ADR_BASE, 32'h8040_0000, base address of the 16-byte register window.
- FIFO_DEPTH, 16, console FIFO depth; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- tcb_vld  in  1  request valid
- tcb_wen  in  1  write enable
- tcb_adr  in  ABW  byte address
- tcb_fn3  in  3  {uns, siz[1:0]}; siz 0=byte, 1=half, 2=word
- tcb_wdt  in  DBW  write data, RISC-V lane packing
- tcb_rdt  out  DBW  read data, valid 1 cycle after transfer (DLY=1)
- tcb_err  out  1  response error, valid 1 cycle after transfer
- tcb_rdy  out  1  responder ready
- con_vld  out  1  console byte valid
- con_dat  out  8  console byte
- con_rdy  in  1  console sink ready
- halt  out  1  sticky halt flag
- exit_code  out  31  value of tohost[31:1] at the halt write

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; it clears every register in the block.
- Reset values: tcb_rdt=0, tcb_err=0, halt=0, exit_code=0, tohost=0, fromhost=0, FIFO empty, con_vld=0. tcb_rdy is combinational and reads 1 while no console push is blocked.
- Transfer: trn = tcb_vld & tcb_rdy.
- Address decode:
  - hit = (tcb_adr[ABW-1:4] == ADR_BASE[ABW-1:4]).
  - Offset = tcb_adr[3:2]: 0 TOHOST, 1 FROMHOST, 2 CONSOLE, 3 STATUS.
- tcb_rdy = ~(tcb_vld & tcb_wen & hit & offset==CONSOLE & fifo_full). The core may hold vld while rdy is low; the request must stay stable during that time.
- Response (DLY=1):
  - tcb_rdt and tcb_err are registered on trn and hold their value between transfers.
  - Write responses drive tcb_rdt=0.
  - tcb_err=1 when any of these hold:
    - miss;
    - TOHOST or FROMHOST accessed with siz!=2 or with adr[1:0]!=0;
    - siz==3.
  - An erroring write has no side effect. An erroring read returns rdt=0.
- TOHOST:
  - Read returns the register.
  - A word write stores wdt.
  - If wdt[0]==1 and halt==0: halt<=1 and exit_code<=wdt[31:1], both on the cycle after trn.
  - halt is sticky. Later TOHOST writes update the register but not halt or exit_code.
- FROMHOST: plain read/write word register, no side effects.
- CONSOLE:
  - Any-size write pushes byte wdt[7:0] into the FIFO; upper bits are ignored.
  - Read returns 0.
- STATUS (read-only; writes are ignored with err=0):
  - [0] halt
  - [1] fifo_full
  - [2] fifo_empty
  - [15:8] fifo count, zero-extended
  - others 0
- Console stream:
  - con_vld = ~fifo_empty; con_dat is the FIFO head.
  - A pop happens when con_vld & con_rdy.
  - Push and pop in the same cycle leave the count unchanged.
  - A push into an empty FIFO makes con_vld=1 on the next cycle (no bypass).
  - When full, a push is blocked by tcb_rdy=0, even if a pop happens in the same cycle; it is accepted in the cycle after space frees.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- After halt, the FIFO keeps draining and the bus stays fully functional.
- Reset mid-operation discards FIFO contents and any pending response.

Decomposition:
- Shared package tcb_htif_pkg holds:
  - register offset enum (TOHOST=0, FROMHOST=1, CONSOLE=2, STATUS=3);
  - STATUS bit-position localparams;
  - TCB siz encodings, reusing tcb_pkg types where they exist.
- One sub-module, tcb_htif_fifo: synchronous FIFO with push/pop, full/empty/count, async active-high reset.

Test Plan:
- Read/write FROMHOST: word write 0xDEAD_BEEF at ADR_BASE+4, then word read → next-cycle rdt=0xDEAD_BEEF, err=0.
- Halt: word write 0x0000_0001 to TOHOST → halt=1 the cycle after trn, exit_code=0. A later write of 0x0000_002B leaves exit_code=0, and a TOHOST read returns 0x2B.
- Exit code: fresh run, write 0x0000_0055 to TOHOST → halt=1, exit_code=0x2A.
- Console backpressure: con_rdy=0, 17 byte writes 'A'..'Q' to CONSOLE with FIFO_DEPTH=16:
  - 16 transfers complete; the 17th sees tcb_rdy=0;
  - STATUS reads 0x0000_1002;
  - raise con_rdy → the 17th completes and bytes appear in order 'A'..'Q'.
- Errors: half write to TOHOST, read at ADR_BASE+16, and read at ADR_BASE+1 with siz=2 → err=1, rdt=0, and tohost stays unchanged.
- Async reset mid-stream: assert rst with 5 bytes queued and con_rdy toggling → all outputs return to reset values immediately, without waiting for a clock edge.
